sdf_bitrev_reorder: RTL and testbench

Output reorder buffer that sits directly downstream of the last SDF NTT stage. That stage emits each N-point frame in bit-reversed index order. This block converts every frame to natural order using two ping-pong register banks of N words each. It streams continuously: one bank is written while the other is read, so back-to-back frames incur no stall.

---
 rtl/sdf_bitrev_reorder.sv | 126 ++++++++++++
 tb/tb_sdf_bitrev_reorder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sdf_bitrev_reorder.sv
// Reorders bit-reversed SDF NTT output frames into natural order.
// Two ping-pong banks of N words: one bank fills while the other drains, so frames stream without stalls.
module sdf_bitrev_reorder #(
  parameter int data_width = 64,
  parameter int log2_n     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int n = 2 ** log2_n;
  localparam logic [log2_n-1:0] last_idx = {log2_n{1'b1}};
  localparam logic [log2_n-1:0] cnt_zero = {log2_n{1'b0}};
  localparam logic [log2_n-1:0] cnt_one  = log2_n'(1);

  // Reverses every bit of a frame index.
  function automatic logic [log2_n-1:0] bitrev(input logic [log2_n-1:0] idx);
    logic [log2_n-1:0] rev;
    for (int i = 0; i < log2_n; i++) begin
      rev[i] = idx[log2_n-1-i];
    end
    return rev;
  endfunction

  // Bank select is the MSB of the address; the low bits are the in-frame index.
  logic [data_width-1:0] mem_r [0:2*n-1];

  logic [log2_n-1:0]     wr_cnt_r, wr_cnt_nxt_s;
  logic                  wr_bank_r, wr_bank_nxt_s;
  logic [log2_n-1:0]     rd_cnt_r, rd_cnt_nxt_s;
  logic                  rd_bank_r, rd_bank_nxt_s;
  logic                  rd_active_r, rd_active_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic [data_width-1:0] out_data_r;
  logic                  frame_done_s;
  logic [data_width-1:0] rd_word_s;

  // Next-state for counters, bank selects and the read-active flag.
  always_comb begin
    frame_done_s    = in_valid && (wr_cnt_r == last_idx);
    wr_cnt_nxt_s    = wr_cnt_r;
    wr_bank_nxt_s   = wr_bank_r;
    rd_cnt_nxt_s    = rd_cnt_r;
    rd_bank_nxt_s   = rd_bank_r;
    rd_active_nxt_s = rd_active_r;
    rd_word_s       = mem_r[{rd_bank_r, rd_cnt_r}];

    if (in_valid) begin
      wr_cnt_nxt_s = wr_cnt_r + cnt_one;
    end else begin
      wr_cnt_nxt_s = wr_cnt_r;
    end

    if (rd_active_r) begin
      rd_cnt_nxt_s    = rd_cnt_r + cnt_one;
      rd_active_nxt_s = (rd_cnt_r != last_idx);
    end else begin
      rd_cnt_nxt_s    = rd_cnt_r;
      rd_active_nxt_s = 1'b0;
    end

    // A completing frame re-arms the reader even on the edge the old read finishes.
    if (frame_done_s) begin
      wr_bank_nxt_s   = ~wr_bank_r;
      rd_bank_nxt_s   = wr_bank_r;
      rd_cnt_nxt_s    = cnt_zero;
      rd_active_nxt_s = 1'b1;
    end else begin
      wr_bank_nxt_s   = wr_bank_r;
      rd_bank_nxt_s   = rd_bank_r;
    end

    busy_nxt_s = (wr_cnt_nxt_s != cnt_zero) || rd_active_nxt_s;
  end

  // Sample storage at the bit-reversed address; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_r[{wr_bank_r, bitrev(wr_cnt_r)}] <= in_data;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r    <= cnt_zero;
      wr_bank_r   <= 1'b0;
      rd_cnt_r    <= cnt_zero;
      rd_bank_r   <= 1'b0;
      rd_active_r <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {data_width{1'b0}};
    end else begin
      wr_cnt_r    <= wr_cnt_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      rd_cnt_r    <= rd_cnt_nxt_s;
      rd_bank_r   <= rd_bank_nxt_s;
      rd_active_r <= rd_active_nxt_s;
      busy_r      <= busy_nxt_s;
      if (rd_active_r) begin
        out_valid_r <= 1'b1;
        out_last_r  <= (rd_cnt_r == last_idx);
        out_data_r  <= rd_word_s;
      end else begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Self-checking bench for sdf_bitrev_reorder: a time-stamped scoreboard predicts every output cycle
// from the frame rule "natural element j = j-th arrival with bit-reversed index".
module tb_sdf_bitrev_reorder;

  localparam int DW = 64;
  localparam int LN = 3;
  localparam int N  = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  sdf_bitrev_reorder #(.data_width(DW), .log2_n(LN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] frame_q[$];
  int            cyc;
  int            n_checks;
  int            n_errors;
  bit            exp_v;
  bit            exp_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int rev_idx(input int k);
    int r;
    r = 0;
    for (int b = 0; b < LN; b++) begin
      if (((k >> b) & 1) != 0) r += 1 << (LN - 1 - b);
    end
    return r;
  endfunction

  // One input cycle; a completed frame schedules its N outputs on edges E+1..E+N.
  task automatic feed(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    frame_q.push_back(d);
    if (frame_q.size() == N) begin
      for (int j = 0; j < N; j++) begin
        exp_t e;
        e.d    = frame_q[rev_idx(j)];
        e.last = (j == N - 1);
        e.cyc  = cyc + 1 + j;
        exp_q.push_back(e);
      end
      frame_q.delete();
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    assert (out_valid === 1'b0 && out_last === 1'b0 && out_data === {DW{1'b0}} && busy === 1'b0)
    else begin
      n_errors++;
      $error("FAIL %s observed v=%b l=%b d=%h b=%b expected all zero", tag, out_valid, out_last, out_data, busy);
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    idle(2);
    n_checks++;
    assert (exp_q.size() == 0 && busy === 1'b0)
    else begin
      n_errors++;
      $error("FAIL %s drain observed pending=%0d busy=%b expected pending=0 busy=0", tag, exp_q.size(), busy);
    end
  endtask

  // Cycle-accurate output monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      n_checks++;
      assert (out_valid === exp_v)
      else begin
        n_errors++;
        $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        assert (out_data === exp_q[0].d && out_last === exp_q[0].last)
        else begin
          n_errors++;
          $error("FAIL out_data cyc=%0d observed=%h/%b expected=%h/%b",
                 cyc, out_data, out_last, exp_q[0].d, exp_q[0].last);
        end
        void'(exp_q.pop_front());
      end
      exp_busy = (frame_q.size() != 0) || ((exp_q.size() > 0) && (exp_q[0].cyc == cyc + 1));
      n_checks++;
      assert (busy === exp_busy)
      else begin
        n_errors++;
        $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, exp_busy);
      end
    end
  end

  initial begin
    logic [DW-1:0] pat1 [N];
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    pat1 = '{64'd0, 64'd4, 64'd2, 64'd6, 64'd1, 64'd5, 64'd3, 64'd7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Test 1: bit-reversed 0..7 comes out as 0..7
    for (int i = 0; i < N; i++) feed(pat1[i]);
    drain("t1");

    // Test 2: in-order input comes out bit-reversed
    for (int i = 0; i < N; i++) feed(64'(10 + i));
    drain("t2");

    // Test 3: three back-to-back random frames
    for (int i = 0; i < 3 * N; i++) feed({$urandom, $urandom});
    drain("t3");

    // Test 4: gapped input, random extra gaps
    for (int i = 0; i < N; i++) begin
      feed({$urandom, $urandom});
      idle(1 + $urandom_range(0, 2));
    end
    drain("t4");

    // Test 5: partial frame discarded by reset
    for (int i = 0; i < 5; i++) feed({$urandom, $urandom});
    rst_n = 1'b0;
    exp_q.delete();
    frame_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("t5_during_reset");
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < N; i++) feed(64'(i));
    drain("t5");

    // Test 6: reset during cycle 3 of a readout, full-width data
    for (int i = 0; i < N; i++) feed(64'hFFFF_FFFF_FFFF_FFF0 + 64'(i));
    idle(3);
    n_checks++;
    assert (out_valid === 1'b1)
    else begin
      n_errors++;
      $error("FAIL t6_readout_active observed=%b expected=1", out_valid);
    end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    frame_q.delete();
    #1;
    check_reset_outputs("t6_async_drop");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("t6_held_reset");
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < N; i++) feed(64'hFFFF_FFFF_FFFF_FFF0 + 64'(i));
    drain("t6_full_width");
    for (int i = 0; i < 2 * N; i++) feed({$urandom, $urandom});
    drain("t6_random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
